// File: rtl/sound_mixer.sv
// Ten-channel sample mixer: snapshots all channels on tick, accumulates one
// channel per clock, saturates the scaled sum to 8 bits and drives a PWM DAC.
module sound_mixer #(
  parameter int SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] bground,
  input  logic [3:0] bamp,
  input  logic [7:0] sfx0,
  input  logic [7:0] sfx1,
  input  logic [7:0] sfx2,
  input  logic [7:0] sfx3,
  input  logic [7:0] sfx4,
  input  logic [7:0] sfx5,
  input  logic [7:0] sfx6,
  input  logic [7:0] sfx7,
  input  logic [7:0] sfx8,
  input  logic [3:0] sfx_amp0,
  input  logic [3:0] sfx_amp1,
  input  logic [3:0] sfx_amp2,
  input  logic [3:0] sfx_amp3,
  input  logic [3:0] sfx_amp4,
  input  logic [3:0] sfx_amp5,
  input  logic [3:0] sfx_amp6,
  input  logic [3:0] sfx_amp7,
  input  logic [3:0] sfx_amp8,
  input  logic [9:0] ch_mask,
  input  logic       clr_overrun,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       busy,
  output logic       overrun,
  output logic       pwm_out
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t      state_q;
  logic [7:0]  samp_in  [10];
  logic [3:0]  amp_in   [10];
  logic [7:0]  samp_q   [10];
  logic [3:0]  amp_q    [10];
  logic [11:0] prod     [10];
  logic [9:0]  mask_q;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  ch_q;
  logic [7:0]  sample_q;
  logic        sample_valid_q;
  logic        busy_q;
  logic        overrun_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  pwm_level_q;
  logic        pwm_out_q;
  logic [15:0] scaled;
  logic [7:0]  sat_d;

  assign samp_in[0] = bground;  assign amp_in[0] = bamp;
  assign samp_in[1] = sfx0;     assign amp_in[1] = sfx_amp0;
  assign samp_in[2] = sfx1;     assign amp_in[2] = sfx_amp1;
  assign samp_in[3] = sfx2;     assign amp_in[3] = sfx_amp2;
  assign samp_in[4] = sfx3;     assign amp_in[4] = sfx_amp3;
  assign samp_in[5] = sfx4;     assign amp_in[5] = sfx_amp4;
  assign samp_in[6] = sfx5;     assign amp_in[6] = sfx_amp5;
  assign samp_in[7] = sfx6;     assign amp_in[7] = sfx_amp6;
  assign samp_in[8] = sfx7;     assign amp_in[8] = sfx_amp7;
  assign samp_in[9] = sfx8;     assign amp_in[9] = sfx_amp8;

  // Per-channel gated products, computed from the snapshot only.
  for (genvar gi = 0; gi < 10; gi++) begin : g_prod
    assign prod[gi] = mask_q[gi] ? ({4'd0, samp_q[gi]} * {8'd0, amp_q[gi]}) : 12'd0;
  end

  assign acc_d  = acc_q + {4'd0, prod[ch_q]};
  assign scaled = acc_q >> SHIFT;
  assign sat_d  = (scaled > 16'd255) ? 8'hFF : scaled[7:0];
  assign cnt_d  = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      ch_q           <= '0;
      mask_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        samp_q[i] <= '0;
        amp_q[i]  <= '0;
      end
    end else begin
      sample_valid_q <= 1'b0;
      // A tick that lands mid-pass outranks a simultaneous clear.
      if (tick && busy_q)
        overrun_q <= 1'b1;
      else if (clr_overrun)
        overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            for (int i = 0; i < 10; i++) begin
              samp_q[i] <= samp_in[i];
              amp_q[i]  <= amp_in[i];
            end
            mask_q  <= ch_mask;
            acc_q   <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          ch_q  <= ch_q + 4'd1;
          if (ch_q == 4'd9)
            state_q <= DONE;
        end
        DONE: begin
          sample_q       <= sat_d;
          sample_valid_q <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Level reloads only at the period boundary so each PWM period is whole.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      pwm_level_q <= '0;
      pwm_out_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pwm_out_q <= (cnt_q < pwm_level_q);
      if (cnt_q == 8'hFF)
        pwm_level_q <= sample_q;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign pwm_out      = pwm_out_q;

endmodule
